// File: rtl/regfile.sv
// Integer register file at the write-back end of the pipeline: two combinational
// read ports with same-cycle write bypass, a hardwired zero register and a commit counter.
module regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wreg,
  input  logic [ADDR_W-1:0] i_wreg_addr,
  input  logic [DATA_W-1:0] i_wreg_data,
  input  logic              i_re1,
  input  logic [ADDR_W-1:0] i_raddr1,
  output logic [DATA_W-1:0] o_rdata1,
  input  logic              i_re2,
  input  logic [ADDR_W-1:0] i_raddr2,
  output logic [DATA_W-1:0] o_rdata2,
  output logic [31:0]       o_wr_cnt
);

  localparam int NREGS = 2**ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic              commit;

  assign commit = i_wreg && (i_wreg_addr != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      o_wr_cnt <= '0;
    end else if (commit) begin
      regs[i_wreg_addr] <= i_wreg_data;
      o_wr_cnt          <= o_wr_cnt + 32'd1;
    end
  end

  // Bypass lets decode see the value MEM/WB retires in this same cycle.
  always_comb begin
    o_rdata1 = '0;
    if (!rst && i_re1 && (i_raddr1 != '0)) begin
      if (i_wreg && (i_wreg_addr == i_raddr1)) o_rdata1 = i_wreg_data;
      else                                     o_rdata1 = regs[i_raddr1];
    end
  end

  always_comb begin
    o_rdata2 = '0;
    if (!rst && i_re2 && (i_raddr2 != '0)) begin
      if (i_wreg && (i_wreg_addr == i_raddr2)) o_rdata2 = i_wreg_data;
      else                                     o_rdata2 = regs[i_raddr2];
    end
  end

endmodule

// File: tb/tb_regfile.sv
// Testbench for regfile: directed scenarios followed by random traffic, all
// checked against an array-based model of the register file.
module tb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_wreg;
  logic [4:0]  i_wreg_addr;
  logic [31:0] i_wreg_data;
  logic        i_re1;
  logic [4:0]  i_raddr1;
  logic [31:0] o_rdata1;
  logic        i_re2;
  logic [4:0]  i_raddr2;
  logic [31:0] o_rdata2;
  logic [31:0] o_wr_cnt;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem_m [32];
  logic [31:0] cnt_m;

  regfile #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_wreg      (i_wreg),
    .i_wreg_addr (i_wreg_addr),
    .i_wreg_data (i_wreg_data),
    .i_re1       (i_re1),
    .i_raddr1    (i_raddr1),
    .o_rdata1    (o_rdata1),
    .i_re2       (i_re2),
    .i_raddr2    (i_raddr2),
    .o_rdata2    (o_rdata2),
    .o_wr_cnt    (o_wr_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_rd(logic re, logic [4:0] a);
    if (rst)                        return 32'h0;
    if (!re)                        return 32'h0;
    if (a == 5'd0)                  return 32'h0;
    if (i_wreg && i_wreg_addr == a) return i_wreg_data;
    return mem_m[a];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Advance one clock and apply the architectural effect of the sampled inputs.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) mem_m[i] = 32'h0;
      cnt_m = 32'h0;
    end else if (i_wreg && i_wreg_addr != 5'd0) begin
      mem_m[i_wreg_addr] = i_wreg_data;
      cnt_m = cnt_m + 32'd1;
    end
    #1;
  endtask

  task automatic cycle();
    #3;
    check("rdata1", o_rdata1, exp_rd(i_re1, i_raddr1));
    check("rdata2", o_rdata2, exp_rd(i_re2, i_raddr2));
    check("wr_cnt", o_wr_cnt, cnt_m);
    tick();
  endtask

  task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic r1, input logic [4:0] a1,
                       input logic r2, input logic [4:0] a2);
    i_wreg = w; i_wreg_addr = wa; i_wreg_data = wd;
    i_re1 = r1; i_raddr1 = a1; i_re2 = r2; i_raddr2 = a2;
  endtask

  initial begin
    cnt_m = 32'h0;
    for (int i = 0; i < 32; i++) mem_m[i] = 32'h0;
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
    @(posedge clk); #1;

    // Reset: two cycles, then every address on both ports reads zero.
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 1'b1, 5'(i));
      #3;
      check("reset_rd1", o_rdata1, 32'h0);
      check("reset_rd2", o_rdata2, 32'h0);
      #(-0);
      tick();
    end
    check("reset_cnt", o_wr_cnt, 32'h0);

    // Basic write then read.
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0);
    cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd0);
    #3;
    check("basic_rd", o_rdata1, 32'hDEADBEEF);
    check("basic_cnt", o_wr_cnt, 32'd1);
    tick();

    // Same-cycle bypass on both ports.
    drive(1'b1, 5'd7, 32'h11111111, 1'b0, 5'd0, 1'b0, 5'd0);
    cycle();
    drive(1'b1, 5'd7, 32'h22222222, 1'b1, 5'd7, 1'b1, 5'd7);
    #3;
    check("byp_rd1", o_rdata1, 32'h22222222);
    check("byp_rd2", o_rdata2, 32'h22222222);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b1, 5'd7);
    #3;
    check("post_byp_rd1", o_rdata1, 32'h22222222);
    check("post_byp_rd2", o_rdata2, 32'h22222222);
    check("post_byp_cnt", o_wr_cnt, 32'd3);
    tick();

    // Zero register ignores writes and does not count them.
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b0, 5'd0);
    #3;
    check("zero_rd_same", o_rdata1, 32'h0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0, 5'd0);
    #3;
    check("zero_rd_next", o_rdata1, 32'h0);
    check("zero_cnt", o_wr_cnt, 32'd3);
    tick();

    // Read-enable gating.
    drive(1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, 5'd0, 1'b0, 5'd0);
    cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd3);
    #3;
    check("re2_off", o_rdata2, 32'h0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd3);
    #3;
    check("re2_on", o_rdata2, 32'hA5A5A5A5);
    tick();

    // Reset beats a simultaneous write and suppresses bypass.
    rst = 1'b1;
    drive(1'b1, 5'd9, 32'h12345678, 1'b1, 5'd9, 1'b1, 5'd9);
    #3;
    check("rst_byp1", o_rdata1, 32'h0);
    check("rst_byp2", o_rdata2, 32'h0);
    tick();
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1, 5'd5);
    #3;
    check("rst_r9", o_rdata1, 32'h0);
    check("rst_r5", o_rdata2, 32'h0);
    check("rst_cnt", o_wr_cnt, 32'h0);
    tick();

    // Random traffic with a narrow address window to force collisions.
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 39) == 0);
      drive(1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7)),
            $urandom,
            ($urandom_range(0, 7) != 0),
            ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7)),
            ($urandom_range(0, 7) != 0),
            ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7)));
      cycle();
    end

    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 1'b1, 5'(31 - i));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- Integer register file on the write-back end of the pipeline.
- Consumes the registered write-back triple (write enable, address, data) from the MEM/WB stage register.
- Serves two read ports to the decode stage.
- Provides same-cycle write-to-read bypass so decode sees the value being retired in that cycle.
- Register 0 is hardwired to zero.

Parameters:
- DATA_W, 32, width of each register and of every data port.
- ADDR_W, 5, register address width; register count is 2**ADDR_W.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- i_wreg  input  1  write enable from MEM/WB.
- i_wreg_addr  input  ADDR_W  write register index.
- i_wreg_data  input  DATA_W  write data.
- i_re1  input  1  read-port-1 enable.
- i_raddr1  input  ADDR_W  read-port-1 index.
- o_rdata1  output  DATA_W  read-port-1 data.
- i_re2  input  1  read-port-2 enable.
- i_raddr2  input  ADDR_W  read-port-2 index.
- o_rdata2  output  DATA_W  read-port-2 data.
- o_wr_cnt  output  32  count of committed writes, for debug and performance.

Behaviour:
- One clock domain, `clk`. Reset `rst` is synchronous and active-high, sampled only on posedge `clk`.
- Storage: 2**ADDR_W registers of DATA_W bits.
- Reset:
  - At a posedge with rst=1, all registers clear to 0 and o_wr_cnt clears to 0.
  - Any write presented in that cycle is discarded.
- Write:
  - At a posedge with rst=0, i_wreg=1 and i_wreg_addr!=0, the register at i_wreg_addr takes i_wreg_data.
  - o_wr_cnt increments by 1 on each such commit and wraps from 0xFFFFFFFF to 0.
  - A write to address 0 is dropped and does not increment o_wr_cnt.
- Read: combinational, zero latency. Each port is evaluated independently, in this priority order:
  1. rst=1 -> 0.
  2. re=0 -> 0.
  3. raddr=0 -> 0.
  4. i_wreg=1 and i_wreg_addr==raddr -> i_wreg_data (bypass).
  5. Otherwise -> stored value.
- Bypass covers the case where MEM/WB retires and decode reads the same register in the same cycle; no extra stall is needed.
- Both ports may read the same address, including the bypassed address, simultaneously; each port returns the identical value.
- Write visibility: after the commit edge, the stored value is returned without bypass.
- Reset mid-operation: a reset asserted between two writes wipes all earlier writes; the first write after reset deasserts commits normally.
- Registers are updated only in the clocked process; the read path contains no latches.

Test Plan:
- Reset check: assert rst for 2 cycles, then read all 32 addresses on both ports with re=1 -> every read returns 0x00000000 and o_wr_cnt=0.
- Basic write/read: write r5=0xDEADBEEF and deassert i_wreg; next cycle raddr1=5, re1=1 -> o_rdata1=0xDEADBEEF; o_wr_cnt=1.
- Same-cycle bypass: with r7 holding 0x11111111, in one cycle drive i_wreg=1, addr=7, data=0x22222222 and raddr1=raddr2=7 -> both ports show 0x22222222 in that cycle; the following cycle, with i_wreg=0, both still show 0x22222222.
- Zero register: write addr 0 with 0xFFFFFFFF while reading port1 addr 0 -> o_rdata1=0 in that cycle and the next; o_wr_cnt unchanged.
- Read enable gating: r3=0xA5A5A5A5, re2=0, raddr2=3 -> o_rdata2=0; set re2=1 -> 0xA5A5A5A5.
- Reset priority: drive i_wreg=1, addr=9, data=0x12345678 together with rst=1 for one cycle, then deassert rst and read r9 -> 0; o_wr_cnt=0; bypass is suppressed during rst.
